// File: rtl/sprite_cmd_scheduler.sv
// rtl/sprite_cmd_scheduler.sv - FIFO-buffered command issuer that defers buffer swaps to vertical blanking
//
// Purpose:
//   Buffers 32-bit command words from the host write port and broadcasts them
//   one per cycle on the shared sprite/background command bus. Flush/swap
//   commands (info == FLUSH_INFO) are held at the head of the queue until
//   vertical blanking, and at most one flush is issued per frame. The block
//   also tracks which buffer is active and how many frames were presented.
//
// Ports:
//   clk_i            system clock
//   reset_i          synchronous active-low reset
//   write_i          host write strobe, writedata_i valid this cycle
//   writedata_i      command word {component[31:26], child[25:21], info[20:17],
//                    type[16:14], buffer[13], data[12:0]}
//   vcount_i         current VGA line
//   cmd_out_o        command word to display components (all zeros when idle)
//   cmd_valid_o      cmd_out_o carries a real command this cycle
//   active_buffer_o  buffer bit of the last issued flush
//   fifo_full_o      queue holds DEPTH entries
//   overflow_o       sticky, a write was dropped because the queue was full
//   frame_count_o    number of flushes issued, wraps at 16'hFFFF

module sprite_cmd_scheduler #(
  parameter int unsigned DEPTH        = 16,
  parameter logic [9:0]  VBLANK_START = 10'd480,
  parameter logic [9:0]  V_TOTAL      = 10'd525,
  parameter logic [3:0]  FLUSH_INFO   = 4'hF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        write_i,
  input  logic [31:0] writedata_i,
  input  logic [9:0]  vcount_i,
  output logic [31:0] cmd_out_o,
  output logic        cmd_valid_o,
  output logic        active_buffer_o,
  output logic        fifo_full_o,
  output logic        overflow_o,
  output logic [15:0] frame_count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_ISSUE       = 1'b0,
    ST_WAIT_VBLANK = 1'b1
  } state_e;

  // Queue storage and bookkeeping
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Control and registered outputs
  state_e        state_q;
  logic          armed_q;
  logic [31:0]   cmd_out_q;
  logic          cmd_valid_q;
  logic          active_buffer_q;
  logic          fifo_full_q;
  logic          overflow_q;
  logic [15:0]   frame_count_q;

  logic [31:0]   head;
  logic          head_is_flush;
  logic          fifo_empty;
  logic          fifo_at_depth;
  logic          in_vblank;
  logic          active_line;
  logic          pop;
  logic          push;
  logic          drop;

  assign head          = mem_q[rd_ptr_q];
  assign head_is_flush = (head[20:17] == FLUSH_INFO);
  assign fifo_empty    = (count_q == '0);
  assign fifo_at_depth = (count_q == DEPTH_C);
  assign in_vblank     = (vcount_i >= VBLANK_START) && (vcount_i < V_TOTAL);
  assign active_line   = (vcount_i < VBLANK_START);

  // Pop decision mirrors the issue branches of the state machine below:
  // normal heads leave immediately in ISSUE, a flush only leaves from
  // WAIT_VBLANK once blanking has started on an armed frame.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == ST_ISSUE) begin
        pop = !head_is_flush;
      end else begin
        pop = in_vblank && armed_q;
      end
    end
    // A pop frees a slot in the same cycle, so a write into a full queue is
    // still accepted when the head leaves.
    push = write_i && (!fifo_at_depth || pop);
    drop = write_i && fifo_at_depth && !pop;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage array is not reset: pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= writedata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      state_q         <= ST_ISSUE;
      armed_q         <= 1'b0;
      cmd_out_q       <= 32'h0;
      cmd_valid_q     <= 1'b0;
      active_buffer_q <= 1'b0;
      fifo_full_q     <= 1'b0;
      overflow_q      <= 1'b0;
      frame_count_q   <= 16'h0;
    end else begin
      // Pointer width equals log2(DEPTH), so increments wrap naturally.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q     <= count_d;
      fifo_full_q <= (count_d == DEPTH_C);

      if (drop) begin
        overflow_q <= 1'b1;
      end

      // Re-arm only on a visible line; blanking and active lines are
      // disjoint, so this never races with the clear on flush issue.
      if (active_line) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        ST_ISSUE: begin
          if (fifo_empty) begin
            cmd_out_q   <= 32'h0;
            cmd_valid_q <= 1'b0;
          end else if (head_is_flush) begin
            // Flush stays queued; everything behind it waits too.
            state_q     <= ST_WAIT_VBLANK;
            cmd_out_q   <= 32'h0;
            cmd_valid_q <= 1'b0;
          end else begin
            cmd_out_q   <= head;
            cmd_valid_q <= 1'b1;
          end
        end

        ST_WAIT_VBLANK: begin
          if (in_vblank && armed_q) begin
            cmd_out_q       <= head;
            cmd_valid_q     <= 1'b1;
            active_buffer_q <= head[13];
            frame_count_q   <= frame_count_q + 16'd1;
            armed_q         <= 1'b0;
            state_q         <= ST_ISSUE;
          end else begin
            // Idle word must be all zeros: consumers decode info blindly.
            cmd_out_q   <= 32'h0;
            cmd_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_ISSUE;
          cmd_out_q   <= 32'h0;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_out_o       = cmd_out_q;
  assign cmd_valid_o     = cmd_valid_q;
  assign active_buffer_o = active_buffer_q;
  assign fifo_full_o     = fifo_full_q;
  assign overflow_o      = overflow_q;
  assign frame_count_o   = frame_count_q;

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// tb/tb_sprite_cmd_scheduler.sv - self-checking bench for sprite_cmd_scheduler

module tb_sprite_cmd_scheduler;

  localparam int DEPTH = 16;
  localparam int VBS   = 480;
  localparam int VTOT  = 525;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [31:0] writedata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        cmd_valid;
  logic        active_buffer;
  logic        fifo_full;
  logic        overflow;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int vc       = 0;

  // Reference model: queue of pending words plus frame-level rules.
  logic [31:0] m_q[$];
  bit          m_hold;
  bit          m_armed;
  bit          m_valid;
  logic [31:0] m_out;
  bit          m_active;
  logic [15:0] m_frames;
  bit          m_ovf;
  bit          m_full;

  always #5 clk = ~clk;

  sprite_cmd_scheduler dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .write_i         (write),
    .writedata_i     (writedata),
    .vcount_i        (vcount),
    .cmd_out_o       (cmd_out),
    .cmd_valid_o     (cmd_valid),
    .active_buffer_o (active_buffer),
    .fifo_full_o     (fifo_full),
    .overflow_o      (overflow),
    .frame_count_o   (frame_count)
  );

  function automatic void model_step(input bit rn, input bit w, input logic [31:0] d, input int v);
    logic [31:0] hd;
    bit vb;
    if (!rn) begin
      m_q.delete();
      m_hold = 0; m_armed = 0; m_valid = 0; m_out = 32'h0;
      m_active = 0; m_frames = 16'h0; m_ovf = 0; m_full = 0;
      return;
    end
    vb = (v >= VBS) && (v < VTOT);
    m_valid = 0;
    m_out = 32'h0;
    if (m_q.size() > 0) begin
      hd = m_q[0];
      if (hd[20:17] == 4'hF) begin
        // A flush first costs one cycle to be noticed, then waits for an armed vblank.
        if (!m_hold) m_hold = 1;
        else if (vb && m_armed) begin
          m_out = m_q.pop_front();
          m_valid = 1;
          m_active = m_out[13];
          m_frames = m_frames + 16'd1;
          m_armed = 0;
          m_hold = 0;
        end
      end else begin
        m_out = m_q.pop_front();
        m_valid = 1;
      end
    end
    if (v < VBS) m_armed = 1;
    if (w) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1;
    end
    m_full = (m_q.size() == DEPTH);
  endfunction

  task automatic tick(input bit w, input logic [31:0] d);
    reset = 1'b1; write = w; writedata = d; vcount = 10'(vc);
    @(posedge clk);
    model_step(1'b1, w, d, vc);
    vc = (vc + 1) % VTOT;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; write = 1'b0; writedata = 32'h0; vcount = 10'(vc);
    @(posedge clk);
    model_step(1'b0, 1'b0, 32'h0, vc);
    vc = (vc + 1) % VTOT;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL reset_cmd_out got %h want 0", cmd_out); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    n_checks++; if (active_buffer !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", active_buffer); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", fifo_full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (frame_count !== 16'h0) begin n_fail++; $display("FAIL reset_frames got %0d want 0", frame_count); end
  endtask

  task automatic test_normal();
    logic [31:0] words [3];
    logic [31:0] exp_d [5];
    bit          exp_v [5];
    words = '{32'h38020005, 32'h38020006, 32'h38020007};
    exp_v = '{0, 1, 1, 1, 0};
    exp_d = '{32'h0, 32'h38020005, 32'h38020006, 32'h38020007, 32'h0};
    do_reset();
    vc = 100;
    for (int i = 0; i < 5; i++) begin
      tick(i < 3, (i < 3) ? words[i] : 32'h0);
      n_checks++; if (cmd_valid !== exp_v[i]) begin n_fail++; $display("FAIL normal_valid[%0d] got %b want %b", i, cmd_valid, exp_v[i]); end
      n_checks++; if (cmd_out !== exp_d[i]) begin n_fail++; $display("FAIL normal_word[%0d] got %h want %h", i, cmd_out, exp_d[i]); end
    end
    n_checks++; if (frame_count !== 16'h0) begin n_fail++; $display("FAIL normal_frames got %0d want 0", frame_count); end
  endtask

  task automatic test_flush();
    int iv = -1;
    int v_now;
    bit idle_bad = 0;
    do_reset();
    vc = 200;
    tick(1'b1, 32'h001E2000);
    for (int i = 0; i < 600 && iv < 0; i++) begin
      v_now = vc;
      tick(1'b0, 32'h0);
      if (cmd_valid) iv = v_now;
      else if (cmd_out !== 32'h0) idle_bad = 1;
    end
    n_checks++; if (iv != VBS) begin n_fail++; $display("FAIL flush_issue_line got %0d want 480", iv); end
    n_checks++; if (idle_bad) begin n_fail++; $display("FAIL flush_idle_word got nonzero want 0"); end
    n_checks++; if (cmd_out !== 32'h001E2000) begin n_fail++; $display("FAIL flush_word got %h want 001e2000", cmd_out); end
    n_checks++; if (active_buffer !== 1'b1) begin n_fail++; $display("FAIL flush_active got %b want 1", active_buffer); end
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL flush_frames got %0d want 1", frame_count); end
    tick(1'b0, 32'h0);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one_cycle got %b want 0", cmd_valid); end
  endtask

  task automatic test_no_overtake();
    int iv = -1;
    int v_now;
    bit early = 0;
    vc = 200;
    tick(1'b1, 32'h001E0000);
    tick(1'b1, 32'h38020009);
    for (int i = 0; i < 600 && iv < 0; i++) begin
      v_now = vc;
      tick(1'b0, 32'h0);
      if (cmd_valid) begin
        iv = v_now;
        if (cmd_out !== 32'h001E0000) early = 1;
      end
    end
    n_checks++; if (iv != VBS) begin n_fail++; $display("FAIL order_flush_line got %0d want 480", iv); end
    n_checks++; if (early) begin n_fail++; $display("FAIL order_first_word got %h want 001e0000", cmd_out); end
    tick(1'b0, 32'h0);
    n_checks++; if (cmd_valid !== 1'b1 || cmd_out !== 32'h38020009) begin n_fail++; $display("FAIL order_follow got %b/%h want 1/38020009", cmd_valid, cmd_out); end
    tick(1'b0, 32'h0);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL order_tail got %b want 0", cmd_valid); end
    n_checks++; if (active_buffer !== 1'b0 || frame_count !== 16'd2) begin n_fail++; $display("FAIL order_state got %b/%0d want 0/2", active_buffer, frame_count); end
  endtask

  task automatic test_back_to_back();
    int lines [$];
    int cyc [$];
    int v_now;
    do_reset();
    vc = 10;
    tick(1'b1, 32'h001E2000);
    tick(1'b1, 32'h001E0000);
    for (int i = 0; i < 1200 && lines.size() < 2; i++) begin
      v_now = vc;
      tick(1'b0, 32'h0);
      if (cmd_valid) begin lines.push_back(v_now); cyc.push_back(i); end
    end
    n_checks++; if (lines.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", lines.size()); end
    else begin
      n_checks++; if (lines[0] != VBS || lines[1] != VBS) begin n_fail++; $display("FAIL b2b_lines got %0d,%0d want 480,480", lines[0], lines[1]); end
      n_checks++; if (cyc[1] - cyc[0] != VTOT) begin n_fail++; $display("FAIL b2b_gap got %0d want 525", cyc[1] - cyc[0]); end
    end
    n_checks++; if (frame_count !== 16'd2 || active_buffer !== 1'b0) begin n_fail++; $display("FAIL b2b_state got %0d/%b want 2/0", frame_count, active_buffer); end
  endtask

  task automatic test_overflow();
    int iv = -1;
    int v_now;
    do_reset();
    vc = 300;
    tick(1'b1, 32'h001E2000);
    for (int i = 1; i < 16; i++) tick(1'b1, 32'h38020000 | 32'(i));
    n_checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_fill got %b/%b want 1/0", fifo_full, overflow); end
    tick(1'b1, 32'h380200AA);
    n_checks++; if (overflow !== 1'b1 || fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_drop got %b/%b want 1/1", overflow, fifo_full); end
    for (int i = 0; i < 600 && iv < 0; i++) begin
      v_now = vc;
      tick(1'b0, 32'h0);
      if (cmd_valid) iv = v_now;
    end
    n_checks++; if (iv != VBS || cmd_out !== 32'h001E2000) begin n_fail++; $display("FAIL ovf_flush got line %0d word %h want 480 001e2000", iv, cmd_out); end
    for (int i = 1; i < 16; i++) begin
      tick(1'b0, 32'h0);
      n_checks++; if (cmd_valid !== 1'b1 || cmd_out !== (32'h38020000 | 32'(i))) begin n_fail++; $display("FAIL ovf_drain[%0d] got %b/%h want 1/%h", i, cmd_valid, cmd_out, 32'h38020000 | 32'(i)); end
    end
    tick(1'b0, 32'h0);
    n_checks++; if (cmd_valid !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_end got %b/%b/%b want 0/0/1", cmd_valid, fifo_full, overflow); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    do_reset();
    vc = 300;
    tick(1'b1, 32'h001E2000);
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h38020100 | 32'(i));
    do_reset();
    n_checks++; if (cmd_out !== 32'h0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out got %h/%b want 0/0", cmd_out, cmd_valid); end
    n_checks++; if (active_buffer !== 1'b0 || frame_count !== 16'h0 || overflow !== 1'b0 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL rmid_state got %b/%0d/%b/%b want 0/0/0/0", active_buffer, frame_count, overflow, fifo_full); end
    for (int i = 0; i < 600; i++) begin
      tick(1'b0, 32'h0);
      if (cmd_valid) stale++;
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rmid_stale got %0d issues want 0", stale); end
  endtask

  task automatic test_random();
    bit w;
    logic [31:0] d;
    int pct;
    do_reset();
    vc = $urandom_range(0, VTOT - 1);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      pct = ((i / 400) % 2 == 1) ? 90 : 30;
      w = ($urandom_range(0, 99) < pct);
      d = $urandom;
      if ($urandom_range(0, 5) == 0) d[20:17] = 4'hF;
      tick(w, d);
      n_checks++; if (cmd_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d got %b want %b", i, cmd_valid, m_valid); end
      n_checks++; if (cmd_out !== m_out) begin n_fail++; $display("FAIL rnd_word@%0d got %h want %h", i, cmd_out, m_out); end
      n_checks++; if (active_buffer !== m_active) begin n_fail++; $display("FAIL rnd_active@%0d got %b want %b", i, active_buffer, m_active); end
      n_checks++; if (frame_count !== m_frames) begin n_fail++; $display("FAIL rnd_frames@%0d got %0d want %0d", i, frame_count, m_frames); end
      n_checks++; if (fifo_full !== m_full) begin n_fail++; $display("FAIL rnd_full@%0d got %b want %b", i, fifo_full, m_full); end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d got %b want %b", i, overflow, m_ovf); end
    end
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; writedata = 32'h0; vcount = 10'h0;
    #1;
    test_reset();
    test_normal();
    test_flush();
    test_no_overtake();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sprite_cmd_scheduler.md
Name: sprite_cmd_scheduler

Overview:
- Sits between the HPS/Avalon write port and the shared 32-bit command bus that feeds every sprite/background display component (Cloud, Mario, etc.).
- Buffers incoming command words in a FIFO and issues them one per cycle.
- Holds buffer-flush/swap commands (info = 4'hF) until vertical blanking, so the double-buffer swap never tears a visible frame.
- Tracks the active buffer and counts presented frames.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 4..64.
- VBLANK_START, 10'd480: first vcount value of vertical blanking.
- V_TOTAL, 10'd525: vcount wrap value; blanking is VBLANK_START <= vcount < V_TOTAL.
- FLUSH_INFO, 4'hF: info-field code identifying a flush/swap command.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- write  input  1  bus write strobe; writedata is valid this cycle.
- writedata  input  32  command word: [31:26] component, [25:21] child, [20:17] info, [16:14] type, [13] buffer, [12:0] data.
- vcount  input  10  current VGA line.
- cmd_out  output  32  command word broadcast to display components.
- cmd_valid  output  1  cmd_out carries a real command this cycle.
- active_buffer  output  1  buffer selected by the last issued flush.
- fifo_full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky; a write was dropped.
- frame_count  output  16  number of flushes issued; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - FIFO emptied; state = ISSUE.
  - cmd_out = 32'h0, cmd_valid = 0, active_buffer = 0, overflow = 0, frame_count = 0, armed = 0.
  - Reset applied mid-operation discards all queued commands.
- Idle word:
  - When cmd_valid = 0, cmd_out = 32'h0 (info = 0, a no-op for all components).
  - Downstream components decode info without looking at cmd_valid, so the idle word must always be all zeros.
- FIFO:
  - On write = 1 and not full, push writedata.
  - On write = 1, full, and no pop in the same cycle: drop the word and set overflow (sticky until reset).
  - Push and pop in the same cycle while full: push is accepted; the count is unchanged.
  - Pointers wrap modulo DEPTH.
  - fifo_full is registered and reflects the count after the edge.
- Vblank window: in_vblank = (vcount >= VBLANK_START) && (vcount < V_TOTAL).
- armed flag:
  - Set on any cycle with vcount < VBLANK_START.
  - Cleared when a flush issues.
  - Guarantees at most one flush per frame.
- ISSUE state, each cycle, evaluating the head entry:
  - FIFO empty: cmd_valid <= 0.
  - Head is not a flush (info != FLUSH_INFO): pop it, cmd_out <= head, cmd_valid <= 1. Normal commands issue at any vcount; they target the back buffer.
  - Head is a flush: go to WAIT_VBLANK without popping; cmd_valid <= 0.
- WAIT_VBLANK state:
  - Output the idle word.
  - When in_vblank && armed: pop the flush, cmd_out <= head, cmd_valid <= 1, active_buffer <= head[13], frame_count <= frame_count + 1, armed <= 0, return to ISSUE.
  - Commands behind a pending flush are not reordered; they wait.
  - Writes keep filling the FIFO while waiting.
- Latency: a word written at edge k into an empty FIFO in state ISSUE appears with cmd_valid = 1 after edge k+1 and is held for exactly one cycle.
- Throughput: one command per cycle.
- Back-to-back flushes: the second flush waits for the next frame (armed only re-sets on an active line).
- Flush with buffer bit equal to active_buffer: still issued and still counted.
- Unknown info codes are passed through unchanged.

Test Plan:
- Three non-flush writes (32'h38020005, 32'h38020006, 32'h38020007) on consecutive cycles at vcount = 100 -> cmd_valid high for three consecutive cycles starting at write edge + 1, words in order; frame_count = 0.
- Flush write 32'h001E2000 at vcount = 200 -> no issue until vcount = 480; then one cycle of cmd_valid with that word; active_buffer = 1; frame_count = 1.
- Flush at vcount = 200, then a non-flush word -> the non-flush word issues exactly one cycle after the flush at vcount = 480; it never overtakes the flush.
- Two flushes queued at vcount = 10 -> first issues at vcount 480 of frame 1; second waits through vcount 0..479 and issues at vcount 480 of frame 2; frame_count = 2.
- A pending flush holds issue at vcount 300 while writes continue -> 16 writes fill the FIFO (fifo_full = 1); a 17th write sets overflow = 1 and is dropped; the flush then issues at vcount 480 followed by the remaining 15 queued words in order.
- reset = 0 for one cycle with 5 entries queued -> all outputs return to their reset values, the queue is empty, and no stale word is issued afterwards.
